// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Optional feature macro: ALU_ARB_DIVZERO_EN (adds rsp_err).
package alu_arb_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 5;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_DIV  = 3'b011,
    OP_MOD  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_GT   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  function automatic logic is_divzero(input logic [2:0] op, input logic [OPND_W-1:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
// rsp_err exists only when ALU_ARB_DIVZERO_EN is defined.
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OPND_W-1:0] req0_a;
  logic [OPND_W-1:0] req0_b;
  logic [2:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [OPND_W-1:0] req1_a;
  logic [OPND_W-1:0] req1_b;
  logic [2:0]        req1_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_data;
`ifdef ALU_ARB_DIVZERO_EN
  logic              rsp_err;
`endif

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
`ifdef ALU_ARB_DIVZERO_EN
    output rsp_err,
`endif
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
`ifdef ALU_ARB_DIVZERO_EN
    input  rsp_err,
`endif
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU producing a 5-bit result.
// Division and modulo by zero return zero.
module alu_core
  import alu_arb_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [2:0]        op,
  output logic [RES_W-1:0]  res
);

  logic [RES_W-1:0] a_x;
  logic [RES_W-1:0] b_x;

  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};

  always_comb begin
    // NOTE: default assignment first keeps this always_comb latch-free.
    res = '0;
    case (op)
      OP_PASS: res = a_x;
      OP_ADD:  res = a_x + b_x;
      OP_SUB:  res = a_x - b_x;
      OP_DIV:  if (b != '0) res = {1'b0, a / b};
      OP_MOD:  if (b != '0) res = {1'b0, a % b};
      OP_SHL:  res = a_x << b;
      OP_SHR:  res = a_x >> b;
      OP_GT:   res = {{(RES_W-1){1'b0}}, (a > b)};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one op in flight.
// Define ALU_ARB_DIVZERO_EN to report divide/mod by zero on rsp_err.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_e            state;
  logic              ptr;
  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [2:0]        op_q;
  logic              id_q;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [RES_W-1:0]  alu_res;

  // Pointer only breaks ties; a lone requester always wins.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);

  assign bus.req0_ready = rst_n && (state == ST_IDLE) && grant0;
  assign bus.req1_ready = rst_n && (state == ST_IDLE) && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;

  alu_core u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= RR_INIT;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= 1'b0;
`ifdef ALU_ARB_DIVZERO_EN
      bus.rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q   <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q   <= grant1 ? bus.req1_b  : bus.req0_b;
            op_q  <= grant1 ? bus.req1_op : bus.req0_op;
            id_q  <= grant1;
            ptr   <= !grant1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.rsp_data  <= alu_res;
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
`ifdef ALU_ARB_DIVZERO_EN
          bus.rsp_err   <= is_divzero(op_q, b_q);
`endif
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
`ifdef ALU_ARB_DIVZERO_EN
            bus.rsp_err   <= 1'b0;
`endif
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model.
// Compile with ALU_ARB_DIVZERO_EN defined to also cover rsp_err.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference ALU written from the opcode definitions with integer arithmetic.
  function automatic int alu_model(input int op, input int a, input int b);
    case (op)
      0: return a;
      1: return a + b;
      2: return (a - b + 32) % 32;
      3: return (b == 0) ? 0 : a / b;
      4: return (b == 0) ? 0 : a % b;
      5: return (a << b) % 32;
      6: return a >> b;
      default: return (a > b) ? 1 : 0;
    endcase
  endfunction

  function automatic int err_model(input int op, input int b);
    return ((op == 3 || op == 4) && b == 0) ? 1 : 0;
  endfunction

  // Transaction-level model: one outstanding op, result visible 2 cycles after accept.
  int  cyc = 0;
  bit  m_live = 0;
  bit  m_busy = 0;
  int  m_acc_cyc;
  bit  m_ptr;
  int  m_id, m_op, m_a, m_b;
  bit  e_valid, e_r0, e_r1, g0, g1;

  always @(negedge clk) begin
    cyc++;
    e_valid = m_live && m_busy && (cyc >= m_acc_cyc + 2);
    g0 = bus.req0_valid && (!bus.req1_valid || !m_ptr);
    g1 = bus.req1_valid && (!bus.req0_valid ||  m_ptr);
    e_r0 = rst_n && m_live && !m_busy && g0;
    e_r1 = rst_n && m_live && !m_busy && g1;
    if (m_live) begin
      check("mon_req0_ready", bus.req0_ready, e_r0);
      check("mon_req1_ready", bus.req1_ready, e_r1);
      check("mon_rsp_valid", bus.rsp_valid, e_valid);
      if (e_valid) begin
        check("mon_rsp_id", bus.rsp_id, m_id);
        check("mon_rsp_data", bus.rsp_data, alu_model(m_op, m_a, m_b));
`ifdef ALU_ARB_DIVZERO_EN
        check("mon_rsp_err", bus.rsp_err, err_model(m_op, m_b));
`endif
      end
    end
    if (!rst_n) begin
      m_live = 1;
      m_busy = 0;
      m_ptr  = 1'b0;
    end else if (m_live) begin
      if (e_valid && bus.rsp_ready) m_busy = 0;
      else if (e_r0 || e_r1) begin
        m_busy    = 1;
        m_acc_cyc = cyc;
        m_id      = e_r1 ? 1 : 0;
        m_op      = e_r1 ? int'(bus.req1_op) : int'(bus.req0_op);
        m_a       = e_r1 ? int'(bus.req1_a)  : int'(bus.req0_a);
        m_b       = e_r1 ? int'(bus.req1_b)  : int'(bus.req0_b);
        m_ptr     = !e_r1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, output int waited);
    bit got = 0;
    waited = 0;
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      waited++;
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    check("issue_ready_seen", got, 1);
    tick();
    if (!id) bus.req0_valid = 1'b0;
    else     bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int waited);
    bit got = 0;
    waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      waited++;
      got = bus.rsp_valid;
    end
    check("rsp_valid_seen", got, 1);
  endtask

  task automatic run_op(input string name, input bit id, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp_data, input bit exp_err, output int w_rdy);
    int w_rsp;
    bus.rsp_ready = 1'b1;
    issue(id, op, a, b, w_rdy);
    wait_rsp(w_rsp);
    check({name, "_latency"}, w_rsp, 2);
    check({name, "_data"}, bus.rsp_data, exp_data);
    check({name, "_id"}, bus.rsp_id, id);
`ifdef ALU_ARB_DIVZERO_EN
    check({name, "_err"}, bus.rsp_err, exp_err);
`else
    if (exp_err) check({name, "_divzero_data"}, bus.rsp_data, 0);
`endif
    tick();
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (6) tick();
  endtask

  int w;
  int grants[$];
  int ids[$];
  bit acc0, acc1;

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 4'd2; bus.req0_b = 4'd4;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
    bus.rsp_ready  = 1'b1;

    check("pin_add",   alu_model(1, 2, 4), 6);
    check("pin_shl1",  alu_model(5, 15, 1), 30);
    check("pin_shl5",  alu_model(5, 15, 5), 0);
    check("pin_sub",   alu_model(2, 2, 4), 30);
    check("pin_gt",    alu_model(7, 5, 3), 1);
    check("pin_div0",  alu_model(3, 9, 0), 0);
    check("pin_div",   alu_model(3, 9, 2), 4);
    check("pin_shr",   alu_model(6, 8, 3), 1);

    @(negedge clk);
    check("reset_ready0_low", bus.req0_ready, 0);
    tick();
    @(negedge clk);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_ready0_held", bus.req0_ready, 0);
`ifdef ALU_ARB_DIVZERO_EN
    check("reset_rsp_err", bus.rsp_err, 0);
`endif
    tick();
    rst_n = 1'b1;

    run_op("add_basic", 1'b0, 3'b001, 4'b0010, 4'b0100, 5'b00110, 1'b0, w);
    check("add_basic_ready_cycle", w, 1);
    run_op("shl_1", 1'b0, 3'b101, 4'b1111, 4'b0001, 5'b11110, 1'b0, w);
    run_op("shl_5", 1'b1, 3'b101, 4'b1111, 4'b0101, 5'b00000, 1'b0, w);
    run_op("sub_wrap", 1'b0, 3'b010, 4'b0010, 4'b0100, 5'b11110, 1'b0, w);
    run_op("cmp_gt", 1'b1, 3'b111, 4'b0101, 4'b0011, 5'b00001, 1'b0, w);
    run_op("div_zero", 1'b1, 3'b011, 4'b1001, 4'b0000, 5'b00000, 1'b1, w);
    run_op("div_two", 1'b1, 3'b011, 4'b1001, 4'b0010, 5'b00100, 1'b0, w);
    run_op("mod_zero", 1'b0, 3'b100, 4'b0111, 4'b0000, 5'b00000, 1'b1, w);
    run_op("shr_4", 1'b0, 3'b110, 4'b1111, 4'b0100, 5'b00000, 1'b0, w);
    run_op("add_carry", 1'b1, 3'b001, 4'b1111, 4'b1111, 5'b11110, 1'b0, w);

    // Both requesters continuously valid after reset: grants must alternate 0,1,0,1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 4'd2; bus.req1_b = 4'd2;
    for (int i = 0; i < 60 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready && grants.size() < 4) grants.push_back(0);
      if (bus.req1_ready && grants.size() < 4) grants.push_back(1);
      if (bus.rsp_valid && bus.rsp_ready) ids.push_back(int'(bus.rsp_id));
    end
    check("rr_grant_count", grants.size(), 4);
    check("rr_id_count", ids.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("rr_grant_order", grants[i], i % 2);
    for (int i = 0; i < 4 && i < ids.size(); i++)    check("rr_id_order", ids[i], i % 2);
    tick();
    drain();

    // Consumer stalls for 5 cycles while req1 waits.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'b000, 4'b1011, 4'b0000, w);
    wait_rsp(w);
    bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 4'd3; bus.req1_b = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_data", bus.rsp_data, 5'b01011);
      check("stall_no_ready", bus.req1_ready, 0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("release_valid_drop", bus.rsp_valid, 0);
    check("release_idle_ready", bus.req1_ready, 1);
    tick();
    drain();

    // Reset while in EXEC: operation discarded, pointer back to RR_INIT.
    issue(1'b0, 3'b001, 4'd5, 4'd5, w);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("exec_reset_no_rsp", bus.rsp_valid, 0);
      tick();
    end
    bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 4'd3; bus.req1_b = 4'd4;
    @(negedge clk);
    check("exec_reset_ptr_r0", bus.req0_ready, 1);
    check("exec_reset_ptr_r1", bus.req1_ready, 0);
    tick();
    drain();
    run_op("after_reset", 1'b1, 3'b001, 4'b0011, 4'b0100, 5'b00111, 1'b0, w);

    // Randomized traffic; requesters hold valid and operands until accepted.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      tick();
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        bus.req0_op    = 3'($urandom);
        bus.req0_a     = 4'($urandom);
        bus.req0_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req1_op    = 3'($urandom);
        bus.req1_a     = 4'($urandom);
        bus.req1_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n         = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, meaning the requester index (0 or 1) holding priority after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid  input  1  requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  operands.
REQ-007 The block SHALL have ports req0_op/req1_op  input  3  opcode: 000 pass a, 001 add, 010 sub, 011 div, 100 mod, 101 shl, 110 shr, 111 a>b.
REQ-008 The block SHALL have port rsp_valid  output  1  result available.
REQ-009 The block SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 The block SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_data  output  5  ALU result.
REQ-012 The block SHALL have port rsp_err  output  1  divide/mod by zero; present only with ALU_ARB_DIVZERO_EN.

Function
REQ-013 FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready=1.
REQ-014 reqN_ready SHALL be asserted combinationally only in IDLE, only for the granted requester, and never for both requesters in one cycle.
REQ-015 Grant SHALL be: single valid requester wins; both valid -> requester indicated by the round-robin pointer wins.
REQ-016 On accept, operands, opcode and requester index SHALL be registered, and the pointer SHALL move to the other requester.
REQ-017 In EXEC the registered operands SHALL be applied to the ALU core and the result registered into rsp_data/rsp_id.
REQ-018 rsp_valid SHALL rise exactly 2 cycles after the accepting edge and hold, with rsp_data/rsp_id stable, until the edge on which rsp_ready=1.
REQ-019 Minimum issue interval SHALL be 3 cycles; rsp_ready held high gives one result per 3 cycles.
REQ-020 Requests arriving in EXEC/RESP SHALL not be accepted; a requester SHALL hold valid and operands until ready.
REQ-021 Add SHALL produce the 5-bit zero-extended sum, carry in bit 4.
REQ-022 Sub SHALL produce (a-b) modulo 32.
REQ-023 Div/mod SHALL produce the unsigned 4-bit quotient/remainder, zero-extended.
REQ-024 Div or mod with b=0 SHALL produce rsp_data=0.
REQ-025 Shl SHALL produce (a<<b) truncated to 5 bits (0 for b>=5); shr SHALL produce a>>b (0 for b>=4).
REQ-026 Compare SHALL produce 1 if a>b unsigned, else 0.
REQ-027 rsp_ready asserted while rsp_valid=0 SHALL be ignored.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, pointer=RR_INIT.
REQ-029 Reset in EXEC or RESP SHALL discard the operation with no response issued; reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-030 With ALU_ARB_DIVZERO_EN defined, rsp_err SHALL be 1 alongside rsp_valid for div/mod with b=0, else 0, registered with rsp_data.
REQ-031 Without ALU_ARB_DIVZERO_EN, port rsp_err SHALL not exist; rsp_data behaviour is unchanged.

Structure
REQ-032 A shared package alu_arb_pkg SHALL hold the opcode constants, the FSM state enum type and operand/result width constants (4, 5).
REQ-033 The ALU SHALL be a purely combinational sub-module alu_core (a, b, op -> 5-bit result) instantiated once.

Verification
REQ-034 Reset, req0 add a=0010 b=0100, rsp_ready=1 -> req0_ready on cycle 1, rsp_valid 2 cycles later, rsp_data=00110, rsp_id=0.
REQ-035 Both valid every cycle, RR_INIT=0 -> grants alternate 0,1,0,1; rsp_id follows the same order.
REQ-036 req1 div a=1001 b=0000 with macro -> rsp_data=00000, rsp_err=1; div a=1001 b=0010 -> 00100, rsp_err=0.
REQ-037 rsp_ready low 5 cycles during RESP -> rsp_valid and rsp_data held stable, no new ready issued; release -> IDLE next cycle.
REQ-038 Shl a=1111 b=0001 -> 11110; shl b=0101 -> 00000; sub a=0010 b=0100 -> 11110; cmp a=0101 b=0011 -> 00001.
REQ-039 rst_n low during EXEC -> no rsp_valid afterwards, pointer=RR_INIT, next request served normally.
